player_sprite_engine: RTL and testbench
=======================================

// Module: player_sprite_engine
// PURPOSE
//  Parametrised player renderer: overlays a vertically stacked, multi-tile, animated sprite on the VGA stream.
//  Owns player X motion: integrates left/right once per frame, clamps to arena bounds, tracks facing.
//  Mirrors the sprite horizontally by facing direction; 2-cycle pipeline matched to a 1-cycle-latency sprite ROM.
//  Sits in the VGA overlay chain between background/arena draw and later overlay stages; one instance per player.
// PARAMETERS
//  WIDTH        64       sprite tile width in pixels (power of 2)
//  HEIGHT       64       sprite tile height in pixels (power of 2)
//  TILES        2        vertically stacked tiles (tile 0 = top/head)
//  ANIM_FRAMES  2        walk-cycle frames (power of 2, >=1)
//  ANIM_DIV     8        video frames per animation step while walking
//  YPOS         600      top row of tile 0
//  X_MIN        0        leftmost allowed xpos
//  X_MAX        885      rightmost allowed xpos (= arena right edge - WIDTH)
//  X_INIT       0        xpos after reset
//  SPEED        2        pixels moved per video frame
//  FACE_INIT    0        facing after reset (0 = right, 1 = left)
//  TRANSPARENT  12'h198  colour key; ROM pixels equal to it pass rgb_in through
// PORTS
//  clk         in   1    pixel clock
//  reset       in   1    asynchronous, active-low reset
//  left        in   1    move-left request, level, sampled at frame tick
//  right       in   1    move-right request, level, sampled at frame tick
//  hcount_in   in   12   horizontal pixel counter
//  hsync_in    in   1    horizontal sync
//  hblnk_in    in   1    horizontal blanking
//  vcount_in   in   12   vertical line counter
//  vsync_in    in   1    vertical sync (rising edge = frame tick)
//  vblnk_in    in   1    vertical blanking
//  rgb_in      in   12   upstream pixel colour
//  rgb_pixel   in   12   sprite ROM data, valid 1 cycle after pixel_addr
//  pixel_addr  out  AW   ROM address {anim, tile, row, col}; AW = clog2(ANIM_FRAMES*TILES*HEIGHT*WIDTH)
//  h/vcount_out, h/vsync_out, h/vblnk_out  out  12/1/1  timing delayed 2 cycles
//  rgb_out     out  12   composited colour, 2-cycle latency
//  xpos_out    out  12   current player left edge
//  facing_out  out  1    0 = right, 1 = left
//  moving_out  out  1    high in WALK_L/WALK_R
// BEHAVIOUR
//  Reset (reset=0, async): all timing/rgb/pixel_addr outputs 0; xpos=X_INIT; facing=FACE_INIT; anim=0; div=0; FSM=IDLE.
//  Frame tick: vsync_in registered; tick = vsync_in & ~vsync_q (one clk). All motion state changes only on tick.
//  FSM {IDLE, WALK_L, WALK_R}, evaluated on tick:
//   left & ~right -> WALK_L: xpos = max(xpos-SPEED, X_MIN), facing=1.
//   right & ~left -> WALK_R: xpos = min(xpos+SPEED, X_MAX), facing=0.
//   both or neither -> IDLE: xpos, facing hold; anim=0, div=0.
//   Arithmetic in 13 bits, no wrap; at X_MIN/X_MAX state stays WALK_*, xpos saturates.
//  Animation: in WALK_*, div increments per tick; at div==ANIM_DIV-1: div=0, anim=(anim+1) mod ANIM_FRAMES.
//   Direction reversal (WALK_L<->WALK_R) keeps anim/div running.
//  Hit test stage 1: dx=hcount_in-xpos, dy=vcount_in-YPOS; hit = 0<=dx<WIDTH and 0<=dy<TILES*HEIGHT.
//   col = facing ? WIDTH-1-dx : dx; tile = dy / HEIGHT; row = dy mod HEIGHT.
//  Stage 1 (cycle N+1): register pixel_addr, hit, blank=hblnk_in|vblnk_in, rgb_in, all timing signals.
//  Stage 2 (cycle N+2): rgb_out = blank ? 0 : (hit && rgb_pixel!=TRANSPARENT) ? rgb_pixel : rgb_in_d;
//   timing outputs = stage-1 copies; exact 2-cycle latency on every output path.
//  xpos/facing/anim change only at vsync rising edge (inside vblank): no mid-frame tearing.
//  Out-of-sprite addresses are don't-care but must be stable-width; hit gates their use.
//  Reset mid-frame: pipeline flushes to 0 immediately; stream resumes with correct 2-cycle alignment.
// STRUCTURE
//  Shared package/header: TRANSPARENT colour key, arena bounds, sprite sizes, FSM state encodings, clog2 helper.
//  Sub-module player_motion_fsm: tick detect, FSM, xpos/facing/anim counters; top keeps hit test + 2-stage pipeline.
// TESTING
//  1 Reset: X_INIT=100, FACE_INIT=0 -> xpos_out=100, facing_out=0, rgb_out=0, moving_out=0 until reset high.
//  2 right held 10 frames, SPEED=2 -> xpos 120, facing 0; left then held 60 frames -> xpos saturates at X_MIN=0.
//  3 left&right both held -> IDLE, xpos frozen, anim reset to 0 on next tick.
//  4 xpos=100, facing=0, pixel (hcount=105, vcount=670) -> pixel_addr {anim,1,6,5}; facing=1 -> col 58.
//  5 ROM returns 12'h198 inside sprite, rgb_in=12'hABC -> rgb_out=12'hABC two cycles later; 12'hF00 -> 12'hF00.
//  6 ANIM_DIV=8, walking 16 frames -> anim steps 0->1->0; hblnk_in=1 -> rgb_out=0 regardless of hit.

Source files
------------

// File: rtl/player_sprite_engine_pkg.sv
// Shared definitions for the player sprite renderer.
// Holds the transparent colour key, default sprite and arena geometry, the
// motion FSM state encoding and small width helpers used to size counters and
// the sprite ROM address.
package player_sprite_engine_pkg;

  localparam logic [11:0] TRANSPARENT_KEY = 12'h198;

  localparam int SPRITE_W        = 64;
  localparam int SPRITE_H        = 64;
  localparam int SPRITE_TILES    = 2;
  localparam int ANIM_FRAMES_DEF = 2;
  localparam int ANIM_DIV_DEF    = 8;
  localparam int YPOS_DEF        = 600;
  localparam int ARENA_X_MIN     = 0;
  localparam int ARENA_X_MAX     = 885;
  localparam int SPEED_DEF       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK_L = 2'd1,
    ST_WALK_R = 2'd2
  } motion_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/player_motion_fsm.sv
// Player horizontal motion and walk-cycle animation.
// Detects the frame tick (rising edge of vsync_in) and, only on that tick,
// moves the player left/right with clamping to [X_MIN, X_MAX], tracks facing
// and advances the animation frame while walking.
// Ports:
//   clk, reset      pixel clock, asynchronous active-low reset
//   vsync_in        vertical sync; its rising edge is the frame tick
//   left, right     level move requests sampled at the tick
//   xpos_out        player left edge
//   facing_out      0 = right, 1 = left
//   moving_out      high while in a walking state
//   anim_out        current walk-cycle frame
module player_motion_fsm
  import player_sprite_engine_pkg::*;
#(
  parameter int ANIM_FRAMES = ANIM_FRAMES_DEF,
  parameter int ANIM_DIV    = ANIM_DIV_DEF,
  parameter int X_MIN       = ARENA_X_MIN,
  parameter int X_MAX       = ARENA_X_MAX,
  parameter int X_INIT      = 0,
  parameter int SPEED       = SPEED_DEF,
  parameter int FACE_INIT   = 0,
  localparam int AFW        = width_of(ANIM_FRAMES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           vsync_in,
  input  logic           left,
  input  logic           right,
  output logic [11:0]    xpos_out,
  output logic           facing_out,
  output logic           moving_out,
  output logic [AFW-1:0] anim_out
);

  localparam int DW = width_of(ANIM_DIV);

  motion_state_e  state_q, state_d;
  logic           vsync_q;
  logic [11:0]    xpos_q, xpos_d;
  logic           facing_q, facing_d;
  logic           moving_q, moving_d;
  logic [AFW-1:0] anim_q, anim_d;
  logic [DW-1:0]  div_q, div_d;
  logic           tick;
  logic           walking;
  logic [12:0]    x_wide;
  logic [12:0]    x_inc;

  always_comb begin
    tick     = vsync_in & ~vsync_q;
    x_wide   = {1'b0, xpos_q};
    x_inc    = x_wide + 13'(SPEED);
    state_d  = state_q;
    xpos_d   = xpos_q;
    facing_d = facing_q;
    anim_d   = anim_q;
    div_d    = div_q;
    walking  = 1'b0;

    if (tick) begin
      if (left && !right) begin
        state_d  = ST_WALK_L;
        facing_d = 1'b1;
        walking  = 1'b1;
        // 13-bit compare so the subtraction can never wrap below X_MIN.
        if (x_wide < 13'(X_MIN) + 13'(SPEED)) xpos_d = 12'(X_MIN);
        else                                  xpos_d = xpos_q - 12'(SPEED);
      end else if (right && !left) begin
        state_d  = ST_WALK_R;
        facing_d = 1'b0;
        walking  = 1'b1;
        if (x_inc > 13'(X_MAX)) xpos_d = 12'(X_MAX);
        else                    xpos_d = x_inc[11:0];
      end else begin
        state_d = ST_IDLE;
        anim_d  = '0;
        div_d   = '0;
      end

      // Walking in either direction keeps the cycle running, so a
      // reversal does not restart the animation.
      if (walking) begin
        if (div_q == DW'(ANIM_DIV - 1)) begin
          div_d  = '0;
          anim_d = (anim_q == AFW'(ANIM_FRAMES - 1)) ? '0 : anim_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end

    moving_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q  <= 1'b0;
      state_q  <= ST_IDLE;
      xpos_q   <= 12'(X_INIT);
      facing_q <= 1'(FACE_INIT);
      moving_q <= 1'b0;
      anim_q   <= '0;
      div_q    <= '0;
    end else begin
      vsync_q  <= vsync_in;
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      facing_q <= facing_d;
      moving_q <= moving_d;
      anim_q   <= anim_d;
      div_q    <= div_d;
    end
  end

  assign xpos_out   = xpos_q;
  assign facing_out = facing_q;
  assign moving_out = moving_q;
  assign anim_out   = anim_q;

endmodule

// File: rtl/player_sprite_engine.sv
// Player sprite overlay for the VGA stream.
// Draws a vertically stacked, animated, horizontally mirrorable sprite at the
// player position and composites it over rgb_in with a colour key. Motion is
// handled by player_motion_fsm; this level does the hit test and the 2-stage
// pixel pipeline.
// Ports:
//   clk, reset                  pixel clock, asynchronous active-low reset
//   left, right                 move requests, sampled at the frame tick
//   h/vcount_in, h/vsync_in,
//   h/vblnk_in, rgb_in          upstream timing and colour
//   rgb_pixel                   sprite ROM word for pixel_addr, needed by
//                               the clock edge after pixel_addr changes
//   pixel_addr                  ROM address {anim, tile, row, col}
//   h/vcount_out, h/vsync_out,
//   h/vblnk_out, rgb_out        timing and composited colour, 2 cycles late
//   xpos_out, facing_out,
//   moving_out                  player state
module player_sprite_engine
  import player_sprite_engine_pkg::*;
#(
  parameter int          WIDTH       = SPRITE_W,
  parameter int          HEIGHT      = SPRITE_H,
  parameter int          TILES       = SPRITE_TILES,
  parameter int          ANIM_FRAMES = ANIM_FRAMES_DEF,
  parameter int          ANIM_DIV    = ANIM_DIV_DEF,
  parameter int          YPOS        = YPOS_DEF,
  parameter int          X_MIN       = ARENA_X_MIN,
  parameter int          X_MAX       = ARENA_X_MAX,
  parameter int          X_INIT      = 0,
  parameter int          SPEED       = SPEED_DEF,
  parameter int          FACE_INIT   = 0,
  parameter logic [11:0] TRANSPARENT = TRANSPARENT_KEY,
  localparam int         AW          = clog2(ANIM_FRAMES * TILES * HEIGHT * WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          left,
  input  logic          right,
  input  logic [11:0]   hcount_in,
  input  logic          hsync_in,
  input  logic          hblnk_in,
  input  logic [11:0]   vcount_in,
  input  logic          vsync_in,
  input  logic          vblnk_in,
  input  logic [11:0]   rgb_in,
  input  logic [11:0]   rgb_pixel,
  output logic [AW-1:0] pixel_addr,
  output logic [11:0]   hcount_out,
  output logic          hsync_out,
  output logic          hblnk_out,
  output logic [11:0]   vcount_out,
  output logic          vsync_out,
  output logic          vblnk_out,
  output logic [11:0]   rgb_out,
  output logic [11:0]   xpos_out,
  output logic          facing_out,
  output logic          moving_out
);

  localparam int CW  = clog2(WIDTH);
  localparam int RW  = clog2(HEIGHT);
  localparam int UW  = AW - RW - CW;
  localparam int AFW = width_of(ANIM_FRAMES);

  localparam logic signed [13:0] YPOS_S   = 14'(YPOS);
  localparam logic signed [13:0] WIDTH_S  = 14'(WIDTH);
  localparam logic signed [13:0] HEIGHT_S = 14'(TILES * HEIGHT);

  logic [AFW-1:0]     anim;
  logic [11:0]        xpos;
  logic               facing;

  logic signed [13:0] dx;
  logic signed [13:0] dy;
  logic [CW-1:0]      col;
  logic [UW-1:0]      upper;
  logic [AW-1:0]      addr_d, addr_q;
  logic               hit_d;
  logic               blank_d;
  logic [11:0]        rgb_out_d;

  logic               hit_p1_q, blank_p1_q;
  logic [11:0]        rgb_p1_q, hcount_p1_q, vcount_p1_q;
  logic               hsync_p1_q, vsync_p1_q, hblnk_p1_q, vblnk_p1_q;
  logic [11:0]        rgb_p2_q, hcount_p2_q, vcount_p2_q;
  logic               hsync_p2_q, vsync_p2_q, hblnk_p2_q, vblnk_p2_q;

  player_motion_fsm #(
    .ANIM_FRAMES (ANIM_FRAMES),
    .ANIM_DIV    (ANIM_DIV),
    .X_MIN       (X_MIN),
    .X_MAX       (X_MAX),
    .X_INIT      (X_INIT),
    .SPEED       (SPEED),
    .FACE_INIT   (FACE_INIT)
  ) u_motion (
    .clk        (clk),
    .reset      (reset),
    .vsync_in   (vsync_in),
    .left       (left),
    .right      (right),
    .xpos_out   (xpos),
    .facing_out (facing),
    .moving_out (moving_out),
    .anim_out   (anim)
  );

  always_comb begin
    dx      = $signed({2'b00, hcount_in}) - $signed({2'b00, xpos});
    dy      = $signed({2'b00, vcount_in}) - YPOS_S;
    hit_d   = (dx >= 14'sd0) && (dx < WIDTH_S) && (dy >= 14'sd0) && (dy < HEIGHT_S);
    // WIDTH is a power of two, so WIDTH-1-dx is the bitwise inverse of dx.
    col     = facing ? ~dx[CW-1:0] : dx[CW-1:0];
    // Upper address field is anim*TILES + tile; equals {anim, tile} when
    // TILES is a power of two. Outside the sprite it is garbage, gated by hit.
    upper   = UW'(anim) * UW'(TILES) + UW'(dy[12:RW]);
    addr_d  = {upper, dy[RW-1:0], col};
    blank_d = hblnk_in | vblnk_in;
    rgb_out_d = blank_p1_q ? 12'h000 :
                (hit_p1_q && (rgb_pixel != TRANSPARENT)) ? rgb_pixel : rgb_p1_q;
  end

  // Stage 1: ROM address, hit, blank and delayed upstream pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      hit_p1_q    <= 1'b0;
      blank_p1_q  <= 1'b0;
      rgb_p1_q    <= '0;
      hcount_p1_q <= '0;
      vcount_p1_q <= '0;
      hsync_p1_q  <= 1'b0;
      vsync_p1_q  <= 1'b0;
      hblnk_p1_q  <= 1'b0;
      vblnk_p1_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      hit_p1_q    <= hit_d;
      blank_p1_q  <= blank_d;
      rgb_p1_q    <= rgb_in;
      hcount_p1_q <= hcount_in;
      vcount_p1_q <= vcount_in;
      hsync_p1_q  <= hsync_in;
      vsync_p1_q  <= vsync_in;
      hblnk_p1_q  <= hblnk_in;
      vblnk_p1_q  <= vblnk_in;
    end
  end

  // Stage 2: composite ROM data over the upstream pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_p2_q    <= '0;
      hcount_p2_q <= '0;
      vcount_p2_q <= '0;
      hsync_p2_q  <= 1'b0;
      vsync_p2_q  <= 1'b0;
      hblnk_p2_q  <= 1'b0;
      vblnk_p2_q  <= 1'b0;
    end else begin
      rgb_p2_q    <= rgb_out_d;
      hcount_p2_q <= hcount_p1_q;
      vcount_p2_q <= vcount_p1_q;
      hsync_p2_q  <= hsync_p1_q;
      vsync_p2_q  <= vsync_p1_q;
      hblnk_p2_q  <= hblnk_p1_q;
      vblnk_p2_q  <= vblnk_p1_q;
    end
  end

  assign pixel_addr = addr_q;
  assign rgb_out    = rgb_p2_q;
  assign hcount_out = hcount_p2_q;
  assign vcount_out = vcount_p2_q;
  assign hsync_out  = hsync_p2_q;
  assign vsync_out  = vsync_p2_q;
  assign hblnk_out  = hblnk_p2_q;
  assign vblnk_out  = vblnk_p2_q;
  assign xpos_out   = xpos;
  assign facing_out = facing;

endmodule

// File: tb/tb_player_sprite_engine.sv
// Testbench for player_sprite_engine: scoreboard of expected output pixels
// plus directed motion/animation checks against a behavioural player model.
module tb_player_sprite_engine;

  localparam int XMAX = 885;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        left, right;
  logic [11:0] hcount_in, vcount_in, rgb_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_pixel;
  logic [13:0] pixel_addr;
  logic [11:0] hcount_out, vcount_out, rgb_out, xpos_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic        facing_out, moving_out;

  player_sprite_engine #(.X_INIT(100), .FACE_INIT(0)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .left       (left),
    .right      (right),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out),
    .xpos_out   (xpos_out),
    .facing_out (facing_out),
    .moving_out (moving_out)
  );

  always #5 clk = ~clk;

  // Sprite ROM stand-in: every fourth column is the transparent key.
  function automatic logic [11:0] rom(input logic [13:0] a);
    if (a[1:0] == 2'b11) return 12'h198;
    return a[11:0] ^ {a[13:12], 10'h2A5};
  endfunction

  assign rgb_pixel = rom(pixel_addr);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Player model
  int m_xpos, m_facing, m_anim, m_div, m_moving;

  task automatic model_reset();
    m_xpos = 100; m_facing = 0; m_anim = 0; m_div = 0; m_moving = 0;
  endtask

  function automatic bit model_hit(input int h, input int v);
    int dx, dy;
    dx = h - m_xpos;
    dy = v - 600;
    return (dx >= 0 && dx < 64 && dy >= 0 && dy < 128);
  endfunction

  function automatic logic [13:0] model_addr(input int h, input int v);
    int dx, dy, col, tile, row;
    logic [5:0] c6, r6;
    logic t1, a1;
    dx   = h - m_xpos;
    dy   = v - 600;
    col  = m_facing ? (63 - dx) : dx;
    tile = dy / 64;
    row  = dy % 64;
    c6 = col[5:0];
    r6 = row[5:0];
    t1 = tile[0];
    a1 = m_anim[0];
    return {a1, t1, r6, c6};
  endfunction

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic [11:0] hc;
    logic [11:0] vc;
    logic [3:0]  sy;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("rgb_out", rgb_out, e.rgb);
      check("hcount_out", hcount_out, e.hc);
      check("vcount_out", vcount_out, e.vc);
      check("sync_out", {hsync_out, vsync_out, hblnk_out, vblnk_out}, e.sy);
    end
  end

  task automatic pix(input int h, input int v, input bit hs, input bit hb, input bit vb,
                     input logic [11:0] rgb);
    exp_t e;
    logic [11:0] rp;
    @(posedge clk); #1;
    hcount_in = 12'(h); vcount_in = 12'(v); rgb_in = rgb;
    hsync_in = hs; hblnk_in = hb; vblnk_in = vb; vsync_in = 1'b0;
    rp = rom(model_addr(h, v));
    e.due = cyc + 2;
    e.hc  = 12'(h);
    e.vc  = 12'(v);
    e.sy  = {hs, 1'b0, hb, vb};
    if (hb || vb)                           e.rgb = 12'h000;
    else if (model_hit(h, v) && rp != 12'h198) e.rgb = rp;
    else                                    e.rgb = rgb;
    sb.push_back(e);
  endtask

  task automatic stream(input int v, input int h0, input int n, input bit hb, input bit vb);
    for (int i = 0; i < n; i++)
      pix(h0 + i, v, (i % 7) == 0, hb, vb, 12'($urandom));
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Issue a hit pixel and compare the registered ROM address one edge later.
  task automatic probe(input string tag, input int h, input int v);
    pix(h, v, 1'b0, 1'b0, 1'b0, 12'h555);
    @(posedge clk); #1;
    check(tag, pixel_addr, model_addr(h, v));
    drain();
  endtask

  task automatic tick(input bit l, input bit r);
    bit walk;
    @(posedge clk); #1;
    left = l; right = r; vsync_in = 1'b1;
    @(posedge clk); #1;
    vsync_in = 1'b0;
    walk = 1'b0;
    if (l && !r) begin
      m_xpos = (m_xpos - 2 < 0) ? 0 : m_xpos - 2;
      m_facing = 1; m_moving = 1; walk = 1'b1;
    end else if (r && !l) begin
      m_xpos = (m_xpos + 2 > XMAX) ? XMAX : m_xpos + 2;
      m_facing = 0; m_moving = 1; walk = 1'b1;
    end else begin
      m_moving = 0; m_anim = 0; m_div = 0;
    end
    if (walk) begin
      if (m_div == 7) begin m_div = 0; m_anim = (m_anim + 1) % 2; end
      else m_div = m_div + 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    left = 1'b1; right = 1'b0;
    hcount_in = 12'd105; vcount_in = 12'd670; rgb_in = 12'hFFF;
    hsync_in = 1'b1; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_xpos", xpos_out, 100);
    check("rst_facing", facing_out, 0);
    check("rst_moving", moving_out, 0);
    check("rst_rgb", rgb_out, 0);
    check("rst_addr", pixel_addr, 0);
    check("rst_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    #2;
    left = 1'b0; vsync_in = 1'b0; hsync_in = 1'b0;
    rst_n = 1'b1;

    // Sprite addressing and colour key at xpos=100, facing right
    pix(105, 670, 1'b0, 1'b0, 1'b0, 12'hABC);
    @(posedge clk); #1;
    check("addr_right", pixel_addr, 14'h1185);
    drain();
    pix(103, 670, 1'b0, 1'b0, 1'b0, 12'hABC);
    pix(300, 670, 1'b0, 1'b0, 1'b0, 12'hF00);
    stream(670, 95, 20, 1'b0, 1'b0);
    stream(599, 98, 6, 1'b0, 1'b0);
    stream(727, 160, 8, 1'b0, 1'b0);
    drain();

    // Walk right, then left into the X_MIN clamp
    repeat (10) tick(1'b0, 1'b1);
    check("xpos_r10", xpos_out, 120);
    check("facing_r10", facing_out, 0);
    check("moving_r10", moving_out, 1);
    repeat (60) tick(1'b1, 1'b0);
    check("xpos_min", xpos_out, m_xpos);
    check("xpos_min_abs", xpos_out, 0);
    check("facing_l", facing_out, 1);
    pix(5, 670, 1'b0, 1'b0, 1'b0, 12'h123);
    @(posedge clk); #1;
    check("col_mirror", pixel_addr[5:0], 58);
    check("addr_mirror", pixel_addr, model_addr(5, 670));
    drain();
    stream(640, 0, 70, 1'b0, 1'b0);
    drain();

    // Two more ticks complete an animation step, then both keys -> IDLE
    repeat (2) tick(1'b1, 1'b0);
    probe("addr_anim1", 10, 610);
    check("anim_before_idle", pixel_addr[13], 1);
    tick(1'b1, 1'b1);
    check("idle_moving", moving_out, 0);
    check("idle_xpos", xpos_out, 0);
    check("idle_facing", facing_out, 1);
    probe("addr_idle", 10, 610);
    check("anim_idle", pixel_addr[13], 0);

    // Animation: 7 walking frames stay on frame 0, the 8th and 16th step it
    repeat (7) tick(1'b0, 1'b1);
    probe("addr_w7", m_xpos + 3, 650);
    check("anim_w7", pixel_addr[13], 0);
    tick(1'b0, 1'b1);
    probe("addr_w8", m_xpos + 3, 650);
    check("anim_w8", pixel_addr[13], 1);
    repeat (8) tick(1'b0, 1'b1);
    probe("addr_w16", m_xpos + 3, 650);
    check("anim_w16", pixel_addr[13], 0);

    // Blanking forces black even over the sprite
    stream(620, m_xpos, 64, 1'b1, 1'b0);
    stream(620, m_xpos, 8, 1'b0, 1'b1);
    drain();

    // Right clamp
    repeat (450) tick(1'b0, 1'b1);
    check("xpos_max", xpos_out, XMAX);
    check("xpos_max_model", xpos_out, m_xpos);
    check("moving_max", moving_out, 1);
    stream(700, 880, 80, 1'b0, 1'b0);
    drain();

    // Reset in the middle of a line
    stream(690, 890, 4, 1'b0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rgb", rgb_out, 0);
    check("midrst_hcount", hcount_out, 0);
    check("midrst_addr", pixel_addr, 0);
    check("midrst_xpos", xpos_out, 100);
    sb.delete();
    model_reset();
    @(negedge clk); #2;
    rst_n = 1'b1;
    stream(670, 95, 16, 1'b0, 1'b0);
    drain();

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
